// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-host single-port memory arbiter.
package mem_arb_pkg;

  localparam int AddrW = 32;
  localparam int DataW = 32;
  localparam int BeW   = 4;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic             we;
    logic [BeW-1:0]   be;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } mem_req_t;

  // Host index width, never narrower than one bit so a single host still has a legal index.
  function automatic int host_idx_w(int num_hosts);
    return (num_hosts > 1) ? $clog2(num_hosts) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_nhost_rr_arbiter.sv
// Same-cycle priority search over host requests; round-robin mode rotates the start point.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int        NumHosts = 2,
  parameter arb_mode_e Mode     = ARB_FIXED,
  localparam int       HostIdxW = host_idx_w(NumHosts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumHosts-1:0] req_i,
  input  logic                en_i,
  output logic [NumHosts-1:0] gnt_o,
  output logic [HostIdxW-1:0] winner_o
);

  logic [HostIdxW-1:0] rr_ptr;
  logic                found;
  int                  idx;

  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NumHosts; i++) begin
      idx = (Mode == ARB_RR) ? i + int'(rr_ptr) : i;
      if (idx >= NumHosts) idx = idx - NumHosts;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        winner_o   = HostIdxW'(idx);
      end
    end
  end

  // Explicit wrap keeps the pointer legal when NumHosts is not a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if ((Mode == ARB_RR) && found) begin
      if (winner_o == HostIdxW'(NumHosts - 1)) rr_ptr <= '0;
      else                                     rr_ptr <= winner_o + HostIdxW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter_nhost.sv
// N-host to single-port RAM arbiter with address decode, zero-latency grant and routed responses.
module mem_arbiter_nhost
  import mem_arb_pkg::*;
#(
  parameter int          NumHosts   = 2,
  parameter bit          RoundRobin = 1'b0,
  parameter int unsigned MemSize    = 65536,
  parameter logic [31:0] MemStart   = 32'h00000000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumHosts-1:0]            host_req_i,
  input  logic [NumHosts-1:0]            host_we_i,
  input  logic [NumHosts-1:0][BeW-1:0]   host_be_i,
  input  logic [NumHosts-1:0][AddrW-1:0] host_addr_i,
  input  logic [NumHosts-1:0][DataW-1:0] host_wdata_i,
  output logic [NumHosts-1:0]            host_gnt_o,
  output logic [NumHosts-1:0]            host_rvalid_o,
  output logic [NumHosts-1:0]            host_err_o,
  output logic [NumHosts-1:0][DataW-1:0] host_rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [BeW-1:0]                 mem_be_o,
  output logic [AddrW-1:0]               mem_addr_o,
  output logic [DataW-1:0]               mem_wdata_o,
  input  logic                           mem_rvalid_i,
  input  logic [DataW-1:0]               mem_rdata_i
);

  localparam int               HostIdxW = host_idx_w(NumHosts);
  localparam arb_mode_e        ArbMode  = RoundRobin ? ARB_RR : ARB_FIXED;
  localparam logic [AddrW-1:0] AddrMask = ~(AddrW'(MemSize) - AddrW'(1));

  logic                active;
  logic [NumHosts-1:0] gnt;
  logic [HostIdxW-1:0] winner;
  logic                any_gnt;
  logic                hit;
  mem_req_t            sel;

  logic                rsp_vld_p1;
  logic                rsp_err_p1;
  logic [HostIdxW-1:0] rsp_host_p1;

  // Arbitration stays off for the first cycle after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) active <= 1'b0;
    else         active <= 1'b1;
  end

  rr_arbiter #(
    .NumHosts (NumHosts),
    .Mode     (ArbMode)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (host_req_i),
    .en_i     (active),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign any_gnt = |gnt;
  assign sel     = '{we:    host_we_i[winner],
                     be:    host_be_i[winner],
                     addr:  host_addr_i[winner],
                     wdata: host_wdata_i[winner]};
  assign hit     = (sel.addr & AddrMask) == MemStart;

  assign host_gnt_o  = gnt;
  assign mem_req_o   = any_gnt && hit;
  assign mem_we_o    = mem_req_o && sel.we;
  assign mem_be_o    = mem_req_o ? sel.be    : '0;
  assign mem_addr_o  = mem_req_o ? sel.addr  : '0;
  assign mem_wdata_o = mem_req_o ? sel.wdata : '0;

  // Stage p1: response owner and error flag, one cycle behind the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_p1  <= 1'b0;
      rsp_host_p1 <= '0;
      rsp_err_p1  <= 1'b0;
    end else begin
      rsp_vld_p1 <= any_gnt;
      if (any_gnt) begin
        rsp_host_p1 <= winner;
        rsp_err_p1  <= !hit;
      end
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (rsp_vld_p1) begin
      host_rvalid_o[rsp_host_p1] = 1'b1;
      host_err_o[rsp_host_p1]    = rsp_err_p1;
      host_rdata_o[rsp_host_p1]  = rsp_err_p1 ? '0 : mem_rdata_i;
    end
  end

  rsp_matches_mem: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i == (rsp_vld_p1 && !rsp_err_p1));

endmodule
